div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle sequencer for the execute-stage divider resource. It accepts a DIV/DIVU request from execute, runs a 32-iteration radix-2 restoring division, and holds the pipeline through the hazard unit's `div_stallE` input until the result is ready. It returns a 64-bit `{remainder, quotient}` word for the HI/LO path, with hi = remainder and lo = quotient. Annul support lets a flush abort an in-flight division.

## Interface
Parameters:
- `WIDTH`, default 32: operand width. Iteration count equals `WIDTH`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: division requested by the instruction in execute. Held high until that instruction leaves execute.
- `signed_div` in 1: 1 = DIV (two's complement), 0 = DIVU. Sampled with `start`.
- `a` in WIDTH: dividend. Sampled only on the accepting edge.
- `b` in WIDTH: divisor. Sampled only on the accepting edge.
- `annul` in 1: flush of execute; aborts any operation.
- `stall` out 1: drives `div_stallE`. Combinational.
- `result_valid` out 1: result present on `result`. Registered.
- `result` out 2*WIDTH: `{remainder, quotient}`. Registered.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `start & ~annul & b!=0`: latch |a|, |b| (absolute values when `signed_div`), the quotient sign (a[MSB]^b[MSB]) and the remainder sign (a[MSB]). Clear the 6-bit counter. Go to RUN.
  - `start & ~annul & b==0`: load result hi=a, lo={WIDTH{1'b1}}. Go to DONE.
- **RUN**
  - Each cycle performs one iteration. Shift {rem, quo} left by 1, then trial-subtract: rem−divisor, computed WIDTH+1 bits wide. If the difference is non-negative, rem=difference and quo[0]=1; otherwise quo[0]=0.
  - Counter increments each cycle. When counter==WIDTH−1, the final iteration completes and the state goes to DONE.
  - The sign fix-up (negate quotient and/or remainder) is applied when loading `result` on the RUN→DONE edge.
- **DONE**
  - `result_valid`=1 for exactly one cycle, then return to IDLE unconditionally.
  - `start` seen high in the following IDLE cycle is a new request, which covers back-to-back divides.
- **Stall:** `stall = ~annul & ((state==IDLE & start) | state==RUN)`. It is 0 in DONE, which lets the instruction advance with its result.
- **Annul:** in any state, the next state is IDLE and `result_valid` is 0 next cycle. `result` keeps its old value.
- **Signed corner case:** −2^31 / −1 gives quotient 0x80000000 and remainder 0. Arithmetic wraps; no trap.
- **Operand stability:** `a` and `b` changes after acceptance are ignored.
- **Reset:** state=IDLE, counter=0, `result`=0, `result_valid`=0, `stall`=0 (while `start`=0).

## Timing
- Request at cycle T (IDLE, b≠0):
  - `stall`=1 in cycles T through T+32 (33 cycles).
  - RUN occupies cycles T+1 through T+32.
  - Cycle T+33: DONE, `result_valid`=1, `stall`=0.
  - Cycle T+34: IDLE.
- Divide by zero at T:
  - `stall`=1 in cycle T only.
  - Cycle T+1: DONE, `result_valid`=1.
- `annul` in the same cycle as `start` in IDLE: the request is not accepted and `stall`=0.
- `rst` has priority over `annul`, which has priority over `start`.
- `rst` mid-RUN: IDLE on the next cycle with no result produced.

## Test plan
- DIVU 100/7: `result`=0x00000002_0000000E. `stall` high 33 cycles, `result_valid` pulse at T+33.
- DIV −7/2: hi=0xFFFFFFFF (−1), lo=0xFFFFFFFD (−3). DIV 7/−2: hi=1, lo=0xFFFFFFFD. DIV 0x80000000/0xFFFFFFFF: hi=0, lo=0x80000000.
- Divide by zero, a=0x12345678, b=0: `stall` high 1 cycle; next cycle `result`=0x12345678_FFFFFFFF with `result_valid`=1.
- `annul` at RUN cycle 10: `stall` drops in that cycle; state IDLE next cycle; no `result_valid` pulse. A fresh DIVU 9/3 afterwards returns hi=0, lo=3 with full 33-cycle latency.
- Back-to-back DIVU 50/5 then 81/9, with `start` held through: two `result_valid` pulses 34 cycles apart, results 0_0000000A then 0_00000009. Changing `a` mid-RUN has no effect.
- `rst` asserted mid-RUN: all outputs 0 next cycle, state IDLE.

Source files
------------

// File: rtl/div_ctrl_if.sv
// Execute-stage <-> divider sequencer handshake: request operands in,
// stall and {remainder, quotient} result out.
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               annul;
  logic               stall;
  logic               result_valid;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, a, b, annul,
    input  stall, result_valid, result
  );

  modport slave (
    input  start, signed_div, a, b, annul,
    output stall, result_valid, result
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU in execute.
// Returns {remainder, quotient}; holds the pipe via stall until DONE.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);
  localparam int CW = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               rv_q, rv_d;
  logic               stall_c;

  // Operand magnitudes; DIVU passes operands through untouched.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  assign a_neg = bus.signed_div & bus.a[WIDTH-1];
  assign b_neg = bus.signed_div & bus.b[WIDTH-1];
  assign a_abs = a_neg ? (~bus.a + 1'b1) : bus.a;
  assign b_abs = b_neg ? (~bus.b + 1'b1) : bus.b;

  // One restoring step: the dividend is shifted out of quo_q into the
  // partial remainder while quotient bits are shifted in from the bottom.
  logic [WIDTH:0]   trial, diff;
  logic [WIDTH-1:0] rem_nx, quo_nx, rem_fix, quo_fix;
  logic             last;
  assign trial   = {rem_q, quo_q[WIDTH-1]};
  assign diff    = trial - {1'b0, dvs_q};
  assign rem_nx  = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_nx  = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
  assign rem_fix = rneg_q ? (~rem_nx + 1'b1) : rem_nx;
  assign quo_fix = qneg_q ? (~quo_nx + 1'b1) : quo_nx;
  assign last    = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    rv_d    = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = bus.start;
        if (bus.start) begin
          if (bus.b != '0) begin
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            res_d   = {bus.a, {WIDTH{1'b1}}};
            rv_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      RUN: begin
        stall_c = 1'b1;
        rem_d   = rem_nx;
        quo_d   = quo_nx;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          res_d   = {rem_fix, quo_fix};
          rv_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flush wins over everything but reset; the last result is retained.
    if (bus.annul) begin
      state_d = IDLE;
      rv_d    = 1'b0;
      res_d   = res_q;
      stall_c = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
    end
  end

  assign bus.stall        = stall_c;
  assign bus.result_valid = rv_q;
  assign bus.result       = res_q;
endmodule

// File: tb/tb_div_ctrl.sv
// Directed self-checking bench for div_ctrl.
module tb_div_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;

  div_ctrl_if #(.WIDTH(32)) bus ();
  div_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and hold start until the result pulse (bounded).
  task automatic run_div(input string nm, input logic [31:0] av, input logic [31:0] bv,
                         input logic sg, input logic [63:0] exp_res,
                         input int exp_stall, input int exp_rv);
    int          stall_n = 0;
    int          rv_at   = -1;
    logic [63:0] res     = '0;
    bus.start = 1'b1; bus.signed_div = sg; bus.a = av; bus.b = bv;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.stall) stall_n++;
      if (bus.result_valid && rv_at < 0) begin rv_at = k; res = bus.result; end
      step();
      if (k == 10) begin bus.a = 32'hDEAD_BEEF; bus.b = 32'h1; end
      if (rv_at >= 0) break;
    end
    bus.start = 1'b0;
    n_chk++;
    if (stall_n !== exp_stall) begin
      n_fail++; $display("FAIL %s stall_cycles got %0d want %0d", nm, stall_n, exp_stall);
    end
    n_chk++;
    if (rv_at !== exp_rv) begin
      n_fail++; $display("FAIL %s rv_cycle got %0d want %0d", nm, rv_at, exp_rv);
    end
    n_chk++;
    if (res !== exp_res) begin
      n_fail++; $display("FAIL %s result got %h want %h", nm, res, exp_res);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.a = '0; bus.b = '0; bus.annul = 1'b0;
    repeat (3) step();
    @(negedge clk);
    n_chk++;
    if ({bus.stall, bus.result_valid, bus.result} !== 66'b0) begin
      n_fail++; $display("FAIL reset outputs got %b/%b/%h want 0/0/0",
                         bus.stall, bus.result_valid, bus.result);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_unsigned();
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, 64'h00000002_0000000E, 33, 33);
    step();
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 33, 33);
    step();
    run_div("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 33, 33);
    step();
    run_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 33);
    step();
  endtask

  task automatic test_div_zero();
    run_div("div_by_zero", 32'h12345678, 32'h0, 1'b0, 64'h12345678_FFFFFFFF, 1, 1);
    step();
  endtask

  task automatic test_annul();
    int rv_n = 0;
    // Annul coincident with start in IDLE: not accepted, no stall.
    bus.start = 1'b1; bus.annul = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd77; bus.b = 32'd5;
    @(negedge clk);
    n_chk++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL annul_idle_stall got %b want 0", bus.stall);
    end
    step();
    bus.start = 1'b0; bus.annul = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bus.result_valid) rv_n++;
      step();
    end
    // Annul during the 10th RUN cycle.
    bus.start = 1'b1; bus.a = 32'd1000; bus.b = 32'd3;
    for (int k = 0; k < 9; k++) step();
    bus.annul = 1'b1;
    @(negedge clk);
    n_chk++;
    if (bus.stall !== 1'b0) begin
      n_fail++; $display("FAIL annul_run_stall got %b want 0", bus.stall);
    end
    step();
    bus.annul = 1'b0; bus.start = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.result_valid || bus.stall) rv_n++;
      step();
    end
    n_chk++;
    if (rv_n !== 0) begin
      n_fail++; $display("FAIL annul_no_result got %0d activity cycles want 0", rv_n);
    end
    run_div("divu_9_3_after_annul", 32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 33, 33);
    step();
  endtask

  task automatic test_back_to_back();
    int          rv_at[2] = '{-1, -1};
    logic [63:0] res[2]   = '{64'h0, 64'h0};
    int          n        = 0;
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd50; bus.b = 32'd5;
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      if (bus.result_valid && n < 2) begin rv_at[n] = k; res[n] = bus.result; n++; end
      step();
      if (k == 12) bus.a = 32'hFFFF_0000;
      if (k == 33) begin bus.a = 32'd81; bus.b = 32'd9; end
      if (k == 50) bus.a = 32'h0000_1234;
      if (n == 2) break;
    end
    bus.start = 1'b0;
    n_chk++;
    if (rv_at[0] !== 33) begin
      n_fail++; $display("FAIL b2b_first_rv got %0d want 33", rv_at[0]);
    end
    n_chk++;
    if (rv_at[1] - rv_at[0] !== 34) begin
      n_fail++; $display("FAIL b2b_spacing got %0d want 34", rv_at[1] - rv_at[0]);
    end
    n_chk++;
    if (res[0] !== 64'h0000000A) begin
      n_fail++; $display("FAIL b2b_res0 got %h want %h", res[0], 64'h0000000A);
    end
    n_chk++;
    if (res[1] !== 64'h00000009) begin
      n_fail++; $display("FAIL b2b_res1 got %h want %h", res[1], 64'h00000009);
    end
    step();
  endtask

  task automatic test_reset_mid_run();
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd500; bus.b = 32'd7;
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1; bus.start = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.stall, bus.result_valid, bus.result} !== 66'b0) begin
      n_fail++; $display("FAIL rst_mid_run got %b/%b/%h want 0/0/0",
                         bus.stall, bus.result_valid, bus.result);
    end
    step();
    run_div("divu_after_rst", 32'd500, 32'd7, 1'b0, 64'h00000003_00000047, 33, 33);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
